// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI-mode command path.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_POLL,
        ST_RESP,
        ST_POST,
        ST_DONE
    } sd_state_e;

    // CRC7 generator x^7 + x^3 + 1 (the x^7 term is implicit)
    localparam logic [6:0] CRC7_POLY = 7'h09;
    // Command frame: command byte, four argument bytes, CRC byte
    localparam int         FRAME_LEN = 6;
    // Idle line value, also what the host clocks out while polling
    localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/sd_crc7.sv
// Combinational CRC7 over a 40-bit message, MSB first, zero seed.
module sd_crc7
    import sd_pkg::*;
(
    input  logic [39:0] data_i,
    output logic [6:0]  crc_o
);

    // Bit-serial LFSR unrolled across all 40 message bits
    always_comb begin
        logic [6:0] crc_d;
        logic       fb_d;
        crc_d = '0;
        fb_d  = 1'b0;
        for (int i = 39; i >= 0; i--) begin
            fb_d  = data_i[i] ^ crc_d[6];
            crc_d = {crc_d[5:0], 1'b0};
            if (fb_d) begin
                crc_d = crc_d ^ CRC7_POLY;
            end
        end
        crc_o = crc_d;
    end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD SPI-mode command engine: frames a command, polls for the R1 start
// byte, captures the remaining response bytes and clocks one trailing byte.
module sd_cmd_engine
    import sd_pkg::*;
#(
    parameter int MAX_RESP_BYTES = 5,
    parameter int NCR_MAX        = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [5:0]                           cmd,
    input  logic [31:0]                          arg,
    input  logic [$clog2(MAX_RESP_BYTES+1)-1:0] nresponse,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 timeout,
    output logic [8*MAX_RESP_BYTES-1:0]          resp,
    output logic                                 spi_ss,
    output logic [7:0]                           spi_tx,
    output logic                                 spi_start,
    input  logic [7:0]                           spi_rx,
    input  logic                                 spi_done
);

    localparam int NR_W  = $clog2(MAX_RESP_BYTES + 1);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] NCR_LAST   = CNT_W'(NCR_MAX - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);

    sd_state_e                   state_q;
    logic [5:0]                  cmd_q;
    logic [31:0]                 arg_q;
    logic [NR_W-1:0]             nresp_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        inflight_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        timeout_q;
    logic                        spi_ss_q;
    logic                        spi_start_q;
    logic [7:0]                  spi_tx_q;
    logic [8*MAX_RESP_BYTES-1:0] resp_q;

    logic [NR_W-1:0]  nresp_d;
    logic [6:0]       crc_d;
    logic [CNT_W-1:0] tx_sel_d;
    logic [7:0]       frame_byte_d;
    logic [CNT_W-1:0] resp_last_d;

    sd_crc7 u_crc7 (
        .data_i ({2'b01, cmd_q, arg_q}),
        .crc_o  (crc_d)
    );

    // Clamp requested response length into 1..MAX_RESP_BYTES
    always_comb begin
        nresp_d = nresponse;
        if (nresponse == '0) begin
            nresp_d = NR_W'(1);
        end else if (nresponse > NR_W'(MAX_RESP_BYTES)) begin
            nresp_d = NR_W'(MAX_RESP_BYTES);
        end
    end

    // Select the frame byte to issue next: byte 0 on the first issue, else the one after cnt_q
    always_comb begin
        tx_sel_d    = inflight_q ? cnt_q + CNT_W'(1) : cnt_q;
        resp_last_d = CNT_W'(nresp_q) - CNT_W'(1);
        case (tx_sel_d)
            8'd0:    frame_byte_d = {2'b01, cmd_q};
            8'd1:    frame_byte_d = arg_q[31:24];
            8'd2:    frame_byte_d = arg_q[23:16];
            8'd3:    frame_byte_d = arg_q[15:8];
            8'd4:    frame_byte_d = arg_q[7:0];
            8'd5:    frame_byte_d = {crc_d, 1'b1};
            default: frame_byte_d = FILL_BYTE;
        endcase
    end

    // Command FSM; every byte after the first is issued on the spi_done edge so transfers run back to back
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            arg_q       <= '0;
            nresp_q     <= NR_W'(1);
            cnt_q       <= '0;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            spi_ss_q    <= 1'b1;
            spi_start_q <= 1'b0;
            spi_tx_q    <= FILL_BYTE;
            resp_q      <= '1;
        end else begin
            spi_start_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cmd_q      <= cmd;
                        arg_q      <= arg;
                        nresp_q    <= nresp_d;
                        resp_q     <= '1;
                        timeout_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        spi_ss_q   <= 1'b0;
                        cnt_q      <= '0;
                        inflight_q <= 1'b0;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!inflight_q) begin
                        spi_start_q <= 1'b1;
                        spi_tx_q    <= frame_byte_d;
                        inflight_q  <= 1'b1;
                    end else if (spi_done) begin
                        spi_start_q <= 1'b1;
                        if (cnt_q == FRAME_LAST) begin
                            cnt_q    <= '0;
                            spi_tx_q <= FILL_BYTE;
                            state_q  <= ST_POLL;
                        end else begin
                            cnt_q    <= cnt_q + CNT_W'(1);
                            spi_tx_q <= frame_byte_d;
                        end
                    end
                end
                ST_POLL: begin
                    if (spi_done) begin
                        spi_start_q <= 1'b1;
                        spi_tx_q    <= FILL_BYTE;
                        if (!spi_rx[7]) begin
                            resp_q[8*MAX_RESP_BYTES-1 -: 8] <= spi_rx;
                            cnt_q   <= CNT_W'(1);
                            state_q <= (nresp_q > NR_W'(1)) ? ST_RESP : ST_POST;
                        end else if (cnt_q == NCR_LAST) begin
                            timeout_q <= 1'b1;
                            state_q   <= ST_POST;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_RESP: begin
                    if (spi_done) begin
                        for (int k = 1; k < MAX_RESP_BYTES; k++) begin
                            if (cnt_q == CNT_W'(k)) begin
                                resp_q[8*(MAX_RESP_BYTES-1-k) +: 8] <= spi_rx;
                            end
                        end
                        spi_start_q <= 1'b1;
                        spi_tx_q    <= FILL_BYTE;
                        if (cnt_q == resp_last_d) begin
                            state_q <= ST_POST;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_POST: begin
                    if (spi_done) begin
                        inflight_q <= 1'b0;
                        spi_ss_q   <= 1'b1;
                        spi_tx_q   <= FILL_BYTE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign resp      = resp_q;
    assign spi_ss    = spi_ss_q;
    assign spi_tx    = spi_tx_q;
    assign spi_start = spi_start_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine with a scripted SPI byte responder.
module tb_sd_cmd_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  cmd = '0;
    logic [31:0] arg = '0;
    logic [2:0]  nresponse = 3'd1;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [39:0] resp;
    logic        spi_ss;
    logic [7:0]  spi_tx;
    logic        spi_start;
    logic [7:0]  spi_rx = 8'hFF;
    logic        spi_done = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_log[$];
    logic [7:0] rx_script[$];
    int         resp_cnt = 0;
    logic [7:0] cur_tx = 8'hFF;
    int         tx_bad_cnt = 0;
    int         done_pulses = 0;
    int         busy_at_done = 0;

    sd_cmd_engine #(.MAX_RESP_BYTES(5), .NCR_MAX(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cmd       (cmd),
        .arg       (arg),
        .nresponse (nresponse),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .resp      (resp),
        .spi_ss    (spi_ss),
        .spi_tx    (spi_tx),
        .spi_start (spi_start),
        .spi_rx    (spi_rx),
        .spi_done  (spi_done)
    );

    always #5 clk = ~clk;

    // Responder: each byte completes two cycles after its spi_start; replies come from rx_script, else 0xFF
    always @(negedge clk) begin
        if (!rst_n) begin
            resp_cnt = 0;
            spi_done = 1'b0;
        end else begin
            if (spi_done) spi_done = 1'b0;
            if (resp_cnt > 0) begin
                if (spi_tx !== cur_tx) tx_bad_cnt++;
                resp_cnt--;
                if (resp_cnt == 0) begin
                    spi_done = 1'b1;
                    spi_rx   = (rx_script.size() > 0) ? rx_script.pop_front() : 8'hFF;
                end
            end
            if (spi_start) begin
                tx_log.push_back(spi_tx);
                cur_tx   = spi_tx;
                resp_cnt = 2;
            end
            if (done) begin
                done_pulses++;
                if (busy) busy_at_done++;
            end
        end
    end

    task automatic run_cmd(input logic [5:0] c, input logic [31:0] a, input logic [2:0] n,
                           output logic ok);
        @(negedge clk);
        cmd = c; arg = a; nresponse = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (spi_ss !== 1'b1)   begin errors++; $display("FAIL reset_ss got %b want 1", spi_ss); end
        checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", spi_start); end
        checks++; if (spi_tx !== 8'hFF)  begin errors++; $display("FAIL reset_tx got %h want ff", spi_tx); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (timeout !== 1'b0)  begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
        checks++; if (resp !== 40'hFFFFFFFFFF) begin errors++; $display("FAIL reset_resp got %h want ffffffffff", resp); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_cmd0();
        logic [7:0] exp_b[9] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
        int base = tx_log.size();
        int dp = done_pulses;
        int tb = tx_bad_cnt;
        int bd = busy_at_done;
        logic ok;
        rx_script = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
        run_cmd(6'd0, 32'h0, 3'd1, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL cmd0_done_seen got %b want 1", ok); end
        checks++; if (tx_log.size() - base != 9) begin errors++; $display("FAIL cmd0_bytes got %0d want 9", tx_log.size() - base); end
        for (int i = 0; i < 9 && base + i < tx_log.size(); i++) begin
            checks++;
            if (tx_log[base+i] !== exp_b[i]) begin errors++; $display("FAIL cmd0_tx[%0d] got %h want %h", i, tx_log[base+i], exp_b[i]); end
        end
        checks++; if (resp !== 40'h01FFFFFFFF) begin errors++; $display("FAIL cmd0_resp got %h want 01ffffffff", resp); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL cmd0_timeout got %b want 0", timeout); end
        checks++; if (done_pulses - dp != 1) begin errors++; $display("FAIL cmd0_done_pulses got %0d want 1", done_pulses - dp); end
        checks++; if (busy_at_done != bd) begin errors++; $display("FAIL cmd0_busy_with_done got %0d want 0", busy_at_done - bd); end
        checks++; if (tx_bad_cnt != tb) begin errors++; $display("FAIL cmd0_tx_stable got %0d want 0", tx_bad_cnt - tb); end
        checks++; if (spi_ss !== 1'b1) begin errors++; $display("FAIL cmd0_ss_after got %b want 1", spi_ss); end
        $display("test_cmd0 done resp=%h", resp);
    endtask

    task automatic test_cmd8_r7();
        logic [7:0] exp_b[13] = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87,
                                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        int base = tx_log.size();
        int tb = tx_bad_cnt;
        logic ok;
        rx_script = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                      8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        run_cmd(6'd8, 32'h1AA, 3'd5, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL r7_done_seen got %b want 1", ok); end
        checks++; if (tx_log.size() - base != 13) begin errors++; $display("FAIL r7_bytes got %0d want 13", tx_log.size() - base); end
        for (int i = 0; i < 13 && base + i < tx_log.size(); i++) begin
            checks++;
            if (tx_log[base+i] !== exp_b[i]) begin errors++; $display("FAIL r7_tx[%0d] got %h want %h", i, tx_log[base+i], exp_b[i]); end
        end
        checks++; if (resp !== 40'h01000001AA) begin errors++; $display("FAIL r7_resp got %h want 01000001aa", resp); end
        checks++; if (tx_bad_cnt != tb) begin errors++; $display("FAIL r7_tx_stable got %0d want 0", tx_bad_cnt - tb); end
        $display("test_cmd8_r7 done resp=%h", resp);
    endtask

    task automatic test_timeout();
        int base = tx_log.size();
        int dp = done_pulses;
        logic ok;
        rx_script.delete();
        run_cmd(6'd0, 32'h0, 3'd1, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_done_seen got %b want 1", ok); end
        checks++; if (tx_log.size() - base != 15) begin errors++; $display("FAIL to_bytes got %0d want 15", tx_log.size() - base); end
        for (int i = 6; i < 15 && base + i < tx_log.size(); i++) begin
            checks++;
            if (tx_log[base+i] !== 8'hFF) begin errors++; $display("FAIL to_tx[%0d] got %h want ff", i, tx_log[base+i]); end
        end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_flag got %b want 1", timeout); end
        checks++; if (resp !== 40'hFFFFFFFFFF) begin errors++; $display("FAIL to_resp got %h want ffffffffff", resp); end
        checks++; if (spi_ss !== 1'b1) begin errors++; $display("FAIL to_ss_after got %b want 1", spi_ss); end
        checks++; if (done_pulses - dp != 1) begin errors++; $display("FAIL to_done_pulses got %0d want 1", done_pulses - dp); end
        $display("test_timeout done timeout=%b", timeout);
    endtask

    task automatic test_ignore_start();
        int base = tx_log.size();
        int dp = done_pulses;
        logic seen;
        rx_script = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
        @(negedge clk);
        cmd = 6'd0; arg = 32'h0; nresponse = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && (tx_log.size() - base) < 2; i++) @(negedge clk);
        cmd = 6'd8; arg = 32'h1AA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL ign_done_seen got %b want 1", seen); end
        checks++; if (tx_log.size() - base != 9) begin errors++; $display("FAIL ign_bytes got %0d want 9", tx_log.size() - base); end
        checks++; if (tx_log.size() > base && tx_log[base] !== 8'h40) begin errors++; $display("FAIL ign_first got %h want 40", tx_log[base]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy got %b want 0", busy); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL ign_timeout got %b want 0", timeout); end
        checks++; if (done_pulses - dp != 1) begin errors++; $display("FAIL ign_done_pulses got %0d want 1", done_pulses - dp); end
        $display("test_ignore_start done");
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_b[6] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
        int base = tx_log.size();
        logic ok;
        rx_script.delete();
        @(negedge clk);
        cmd = 6'd8; arg = 32'h1AA; nresponse = 3'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && (tx_log.size() - base) < 2; i++) @(negedge clk);
        checks++; if (tx_log.size() - base < 2) begin errors++; $display("FAIL rmid_progress got %0d want 2", tx_log.size() - base); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (spi_ss !== 1'b1) begin errors++; $display("FAIL rmid_ss got %b want 1", spi_ss); end
        checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL rmid_start got %b want 0", spi_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rx_script = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
        base = tx_log.size();
        run_cmd(6'd0, 32'h0, 3'd1, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rmid_done_seen got %b want 1", ok); end
        checks++; if (tx_log.size() - base != 9) begin errors++; $display("FAIL rmid_bytes got %0d want 9", tx_log.size() - base); end
        for (int i = 0; i < 6 && base + i < tx_log.size(); i++) begin
            checks++;
            if (tx_log[base+i] !== exp_b[i]) begin errors++; $display("FAIL rmid_tx[%0d] got %h want %h", i, tx_log[base+i], exp_b[i]); end
        end
        checks++; if (resp !== 40'h01FFFFFFFF) begin errors++; $display("FAIL rmid_resp got %h want 01ffffffff", resp); end
        $display("test_reset_mid done");
    endtask

    task automatic test_nresp_clamp();
        int base;
        logic ok;
        base = tx_log.size();
        rx_script = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00};
        run_cmd(6'd0, 32'h0, 3'd0, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL n0_done_seen got %b want 1", ok); end
        checks++; if (tx_log.size() - base != 8) begin errors++; $display("FAIL n0_bytes got %0d want 8", tx_log.size() - base); end
        checks++; if (resp !== 40'h01FFFFFFFF) begin errors++; $display("FAIL n0_resp got %h want 01ffffffff", resp); end
        base = tx_log.size();
        rx_script = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                      8'h01, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h55, 8'h66};
        run_cmd(6'd8, 32'h1AA, 3'd7, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL n7_done_seen got %b want 1", ok); end
        checks++; if (tx_log.size() - base != 12) begin errors++; $display("FAIL n7_bytes got %0d want 12", tx_log.size() - base); end
        checks++; if (resp !== 40'h01000001AA) begin errors++; $display("FAIL n7_resp got %h want 01000001aa", resp); end
        rx_script.delete();
        $display("test_nresp_clamp done");
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8_r7();
        test_timeout();
        test_ignore_start();
        test_reset_mid();
        test_nresp_clamp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_cmd_engine.md
SD_CMD_ENGINE -- requirements
Module: sd_cmd_engine

Interface
REQ-001 SHALL have parameter MAX_RESP_BYTES, default 5, meaning the maximum number of response bytes captured (R1=1, R7/R3=5).
REQ-002 SHALL have parameter NCR_MAX, default 8, meaning the maximum number of 0xFF poll bytes sent before a response is declared absent.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle command request.
REQ-006 SHALL have port cmd  input  6  SD command index.
REQ-007 SHALL have port arg  input  32  command argument.
REQ-008 SHALL have port nresponse  input  $clog2(MAX_RESP_BYTES+1)  number of response bytes expected.
REQ-009 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port timeout  output  1  no response within NCR_MAX polls; held until next accepted start.
REQ-012 SHALL have port resp  output  8*MAX_RESP_BYTES  captured response; first byte in the MSB byte lane.
REQ-013 SHALL have port spi_ss  output  1  card select, active-low.
REQ-014 SHALL have port spi_tx  output  8  byte to shift out.
REQ-015 SHALL have port spi_start  output  1  one-cycle byte-transfer request to the SPI byte engine.
REQ-016 SHALL have port spi_rx  input  8  received byte, valid when spi_done=1.
REQ-017 SHALL have port spi_done  input  1  one-cycle pulse ending a byte transfer.

Function
REQ-018 SHALL have the states IDLE, SEND, POLL, RESP, POST and DONE.
REQ-019 In IDLE, start=1 SHALL latch cmd, arg and nresponse, set resp to all 0xFF, clear timeout and enter SEND; start outside IDLE SHALL be ignored.
REQ-020 nresponse=0 SHALL be treated as 1, and nresponse>MAX_RESP_BYTES SHALL be clamped to MAX_RESP_BYTES.
REQ-021 The frame SHALL be {2'b01,cmd}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc7,1'b1}.
REQ-022 crc7 SHALL use polynomial x^7+x^3+1 with initial value 0, computed MSB-first over the first 40 frame bits.
REQ-023 spi_ss SHALL be 0 in SEND, POLL, RESP and POST, and 1 otherwise.
REQ-024 spi_start SHALL pulse for one cycle per byte, and the next pulse SHALL occur exactly one cycle after the previous spi_done.
REQ-025 The first spi_start SHALL occur one cycle after entering SEND.
REQ-026 spi_tx SHALL remain stable from spi_start until the matching spi_done.
REQ-027 SEND SHALL transmit the 6 frame bytes in order, with received bytes discarded, and then enter POLL.
REQ-028 POLL SHALL transmit 0xFF and capture the first spi_rx with bit7=0 into resp byte 0.
REQ-029 After the POLL capture, the engine SHALL enter RESP if nresponse>1, else POST.
REQ-030 If NCR_MAX poll bytes all return bit7=1, the engine SHALL set timeout=1 and enter POST with resp unchanged (all 0xFF).
REQ-031 RESP SHALL transmit 0xFF and store each spi_rx into resp bytes 1..nresponse-1, then enter POST.
REQ-032 POST SHALL transmit one 0xFF byte and then enter DONE.
REQ-033 DONE SHALL assert done=1 for exactly one cycle, and the engine SHALL return to IDLE on the next cycle.
REQ-034 busy SHALL fall in the same cycle that done=1.
REQ-035 start coincident with done SHALL be ignored.
REQ-036 spi_tx SHALL be 0xFF whenever no frame byte is being sent.
REQ-037 spi_done outside SEND, POLL, RESP and POST SHALL be ignored.

Reset
REQ-038 rst_n=0 at a clock edge SHALL force state=IDLE, busy=0, done=0, timeout=0, spi_ss=1, spi_start=0, spi_tx=8'hFF and resp=all 0xFF, and SHALL abort any transfer.
REQ-039 Reset SHALL take priority over every other input.

Structure
REQ-040 Package sd_pkg SHALL hold the state enum, the CRC7 polynomial constant (7'h09), the frame length (6) and the 0xFF fill constant.
REQ-041 Sub-module sd_crc7 (combinational, 40-bit in, 7-bit out) SHALL compute crc7 and be reused by later data-path blocks.

Verification
REQ-042 The bench SHALL cover: cmd=0, arg=0, nresponse=1, responder returns 0x01 on the 2nd poll -> spi_tx 40 00 00 00 00 95, 2 poll bytes, resp top byte=0x01, timeout=0, one done pulse.
REQ-043 The bench SHALL cover: cmd=8, arg=0x1AA, nresponse=5, responder R7 -> frame 48 00 00 01 AA 87, resp=0x01_00_00_01_AA.
REQ-044 The bench SHALL cover: responder always 0xFF -> exactly 8 poll bytes, then 1 POST byte, timeout=1, resp all 0xFF, spi_ss high after done.
REQ-045 The bench SHALL cover: start pulsed during SEND and again on the done cycle -> both ignored, exactly one 6-byte frame seen.
REQ-046 The bench SHALL cover: rst_n=0 mid-SEND -> next cycle spi_ss=1, spi_start=0, busy=0, and a new start afterwards produces a full correct frame.
REQ-047 The bench SHALL cover: nresponse=0 -> behaves as 1; nresponse=7 -> 5 bytes captured.
